// File: rtl/biquad_cascade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : biquad_cascade_sequencer
// Purpose  : Stages host coefficient writes, replays them onto the biquad
//            configuration bus in a quiet window, and generates the
//            decimation strobe.
// Revision : 1.0 - initial release
// ============================================================================
module biquad_cascade_sequencer #(
   parameter int unsigned NUM_SECTIONS          = 4,
   parameter logic [31:0] CONFIGURATION_ADDRESS = 32'd998,
   parameter logic [31:0] STAGING_ADDRESS       = 32'd1100,
   parameter logic [31:0] SECTION_BASE_ADDRESS  = 32'd1000,
   parameter int unsigned COEFFICIENT_Q         = 28,
   parameter int unsigned HOLD_CYCLES           = 2,
   parameter int unsigned GUARD_CYCLES          = 4,
   parameter logic [31:0] DECII_DEFAULT         = 32'd64
) (
   input  logic         aclk,
   input  logic         reset,
   input  logic [31:0]  config_addr,
   input  logic [511:0] config_data,
   output logic [31:0]  bq_config_addr,
   output logic [511:0] bq_config_data,
   output logic         axis_decii_clk,
   output logic         busy,
   output logic         done,
   output logic         cfg_error,
   output logic [15:0]  update_count
);

   localparam int unsigned  C_IDX_W      = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
   localparam logic [191:0] C_SLOT_RESET = 192'((64'd1 << COEFFICIENT_Q) - 64'd1);
   localparam logic [31:0]  C_DIV_MIN    = 32'd4;
   localparam logic [15:0]  C_GUARD_LOAD = 16'(GUARD_CYCLES - 1);
   localparam logic [15:0]  C_HOLD_LOAD  = 16'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GUARD  = 3'd1,
      S_WRITE  = 3'd2,
      S_GAP    = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             timer_q, timer_d;
   logic [NUM_SECTIONS-1:0] pend_q, pend_d;
   logic [31:0]             div_q, div_d;
   logic [31:0]             cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic [15:0]             count_q, count_d;
   logic [191:0]            slot_q [NUM_SECTIONS];

   logic [31:0]             w_stage_off;
   logic                    w_stage_hit;
   logic                    w_ctrl_hit;
   logic                    w_busy;
   logic                    w_ctrl_ok;
   logic [NUM_SECTIONS-1:0] w_ctrl_mask;
   logic [31:0]             w_div_load;
   logic [C_IDX_W-1:0]      w_idx;
   logic                    w_unused;

   assign w_stage_off = config_addr - STAGING_ADDRESS;
   assign w_stage_hit = (w_stage_off < 32'(NUM_SECTIONS));
   assign w_ctrl_hit  = (config_addr == CONFIGURATION_ADDRESS);
   assign w_busy      = (state_q == S_GUARD) || (state_q == S_WRITE) || (state_q == S_GAP);
   assign w_ctrl_ok   = w_ctrl_hit && !w_busy;
   assign w_ctrl_mask = config_data[32 +: NUM_SECTIONS];
   assign w_div_load  = (config_data[31:0] < C_DIV_MIN) ? C_DIV_MIN : config_data[31:0];
   assign w_unused    = &{1'b0, config_data[511:192]};

   // Lowest pending section is served first.
   always_comb begin
      w_idx = '0;
      for (int i = NUM_SECTIONS - 1; i >= 0; i--) begin
         if (pend_q[i]) w_idx = C_IDX_W'(i);
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         pend_q  <= '0;
         div_q   <= DECII_DEFAULT;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         for (int k = 0; k < NUM_SECTIONS; k++) slot_q[k] <= C_SLOT_RESET;
      end else if (w_stage_hit && !w_busy) begin
         slot_q[w_stage_off[C_IDX_W-1:0]] <= config_data[191:0];
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE, S_FINISH: begin
            state_d = S_IDLE;
            if (w_ctrl_ok && (|w_ctrl_mask)) begin
               state_d = S_GUARD;
               timer_d = C_GUARD_LOAD;
               pend_d  = w_ctrl_mask;
            end
         end
         S_GUARD: begin
            if (timer_q == '0) begin
               state_d = S_WRITE;
               timer_d = C_HOLD_LOAD;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         S_WRITE: begin
            if (timer_q == '0) begin
               state_d = S_GAP;
               pend_d  = pend_q & (pend_q - NUM_SECTIONS'(1));
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         S_GAP: begin
            if (|pend_q) begin
               state_d = S_WRITE;
               timer_d = C_HOLD_LOAD;
            end else begin
               state_d = S_FINISH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_d   = div_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      count_d = count_q;
      if (w_busy) begin
         if (w_ctrl_hit || w_stage_hit) err_d = 1'b1;
      end else if (w_ctrl_hit) begin
         div_d = w_div_load;
         err_d = 1'b0;
      end
      // Counter restarts on a divider load and again as the sequence finishes.
      if (w_ctrl_ok) begin
         cnt_d = '0;
      end else if ((state_q == S_GAP) && (pend_q == '0)) begin
         cnt_d   = '0;
         count_d = count_q + 16'd1;
      end else if (!w_busy) begin
         cnt_d = (cnt_q >= div_q - 32'd1) ? '0 : cnt_q + 32'd1;
      end
   end

   always_comb begin
      bq_config_addr = '0;
      bq_config_data = '0;
      if (state_q == S_WRITE) begin
         bq_config_addr = SECTION_BASE_ADDRESS + 32'(w_idx);
         bq_config_data = {320'b0, slot_q[w_idx]};
      end
   end

   assign axis_decii_clk = !w_busy && (cnt_q == div_q - 32'd1);
   assign busy           = w_busy;
   assign done           = (state_q == S_FINISH);
   assign cfg_error      = err_q;
   assign update_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_biquad_cascade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_biquad_cascade_sequencer
// Purpose  : Scoreboard bench for biquad_cascade_sequencer with a cycle-level
//            reference model of the commit sequence and decimation strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biquad_cascade_sequencer;

   localparam int NS    = 4;
   localparam int CFG_A = 998;
   localparam int STG_A = 1100;
   localparam int SEC_A = 1000;
   localparam int G     = 4;
   localparam int H     = 2;
   localparam int DIV0  = 64;
   localparam logic [191:0] SLOT_RST = 192'h0FFF_FFFF;

   typedef struct {
      int           cyc;
      logic [31:0]  addr;
      logic [511:0] data;
   } beat_t;

   typedef struct {
      int          cyc;
      logic [15:0] cnt;
   } done_t;

   logic         aclk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  config_addr = '0;
   logic [511:0] config_data = '0;
   logic [31:0]  bq_config_addr;
   logic [511:0] bq_config_data;
   logic         axis_decii_clk;
   logic         busy;
   logic         done;
   logic         cfg_error;
   logic [15:0]  update_count;

   biquad_cascade_sequencer dut (
      .aclk           (aclk),
      .reset          (reset),
      .config_addr    (config_addr),
      .config_data    (config_data),
      .bq_config_addr (bq_config_addr),
      .bq_config_data (bq_config_data),
      .axis_decii_clk (axis_decii_clk),
      .busy           (busy),
      .done           (done),
      .cfg_error      (cfg_error),
      .update_count   (update_count)
   );

   initial forever #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // Reference model state
   logic [191:0] m_slot [NS];
   int           m_div = DIV0;
   int           m_next_stb = 0;
   int           m_bs = 0;
   int           m_be = -1;
   bit           m_err = 1'b0;
   int           m_count = 0;
   bit           mon_en = 1'b0;
   beat_t        beat_q[$];
   done_t        done_q[$];
   logic [31:0]  others [5] = '{32'd999, 32'd1000, 32'd1003, 32'd1099, 32'd1104};

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset(input int c);
      for (int k = 0; k < NS; k++) m_slot[k] = SLOT_RST;
      m_div      = DIV0;
      m_err      = 1'b0;
      m_count    = 0;
      m_next_stb = c + DIV0 - 1;
      beat_q.delete();
      done_q.delete();
      if (m_be >= c) m_be = c - 1;
   endtask

   // Write presented during cycle t; applied to the model once it has been sampled.
   task automatic model_write(input int t, input logic [31:0] a, input logic [511:0] d);
      bit         bz;
      int         s;
      int         dv;
      logic [7:0] mk;
      bz = (t >= m_bs) && (t <= m_be);
      if (a >= STG_A && a < STG_A + NS) begin
         if (bz) m_err = 1'b1;
         else m_slot[a - STG_A] = d[191:0];
      end else if (a == CFG_A) begin
         if (bz) begin
            m_err = 1'b1;
         end else begin
            dv    = (d[31:0] < 4) ? 4 : int'(d[31:0]);
            m_div = dv;
            m_err = 1'b0;
            mk    = d[39:32] & 8'((1 << NS) - 1);
            if (mk == 8'd0) begin
               m_next_stb = t + dv;
            end else begin
               m_bs = t + 1;
               s    = t + 1 + G;
               for (int k = 0; k < NS; k++) begin
                  if (mk[k]) begin
                     for (int h = 0; h < H; h++)
                        beat_q.push_back('{s + h, 32'(SEC_A + k), {320'b0, m_slot[k]}});
                     s += H + 1;
                  end
               end
               m_be    = s - 1;
               m_count = (m_count + 1) % 65536;
               done_q.push_back('{s, 16'(m_count)});
               m_next_stb = s + dv - 1;
            end
         end
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [511:0] d);
      int t;
      t           = cyc;
      config_addr = a;
      config_data = d;
      @(posedge aclk);
      model_write(t, a, d);
      #1;
      config_addr = '0;
      config_data = '0;
   endtask

   task automatic ctrl(input int dv, input int mk);
      logic [511:0] d;
      d        = '0;
      d[31:0]  = 32'(dv);
      d[39:32] = 8'(mk);
      wr(32'(CFG_A), d);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic do_reset(input int n);
      int c0;
      c0    = cyc;
      reset = 1'b1;
      for (int i = 1; i <= n; i++) begin
         @(posedge aclk);
         model_reset(c0 + i);
         mon_en = 1'b1;
      end
      #1;
      reset = 1'b0;
   endtask

   // Monitor: compares every cycle against the model and the expectation queues.
   always @(negedge aclk) begin
      beat_t b;
      done_t dn;
      logic  eb;
      logic  es;
      if (mon_en) begin
         eb = (cyc >= m_bs) && (cyc <= m_be);
         es = (cyc == m_next_stb);
         if (es) m_next_stb = m_next_stb + m_div;
         check("busy", busy, eb);
         check("strobe", axis_decii_clk, es);
         check("cfg_error", cfg_error, m_err);
         if (bq_config_addr != '0) begin
            if (beat_q.size() == 0) begin
               check("beat_unexpected_addr", bq_config_addr, 0);
            end else begin
               b = beat_q.pop_front();
               check("beat_cycle", cyc, b.cyc);
               check("beat_addr", bq_config_addr, b.addr);
               check("beat_data", bq_config_data, b.data);
            end
         end else begin
            check("idle_bus_data", bq_config_data, 0);
            if (beat_q.size() > 0 && beat_q[0].cyc <= cyc) begin
               check("beat_missing_addr", bq_config_addr, beat_q[0].addr);
               void'(beat_q.pop_front());
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               check("done_unexpected", done, 1'b0);
            end else begin
               dn = done_q.pop_front();
               check("done_cycle", cyc, dn.cyc);
               check("done_update_count", update_count, dn.cnt);
            end
         end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
            check("done_missing", done, 1'b1);
            void'(done_q.pop_front());
         end
      end
   end

   initial begin
      logic [511:0] d;
      int           op;

      // Reset and free-running idle strobe
      do_reset(3);
      check("reset_update_count", update_count, 16'd0);
      check("reset_bus_addr", bq_config_addr, 0);
      check("reset_done", done, 1'b0);
      idle(200);

      // Reset aborts a mask=0xF sequence at t+6
      ctrl(64, 'hF);
      idle(5);
      do_reset(2);
      check("abort_update_count", update_count, 16'd0);
      check("abort_busy", busy, 1'b0);
      idle(5);
      ctrl(64, 'hF);
      idle(30);

      // Stage slot 0 and commit a single section
      d = '0;
      d[191:0] = {32'h04000000, 32'hE0000000, 32'h0, 32'h08000000, 32'h10000000, 32'h08000000};
      wr(32'(STG_A), d);
      idle(3);
      ctrl(16, 'h1);
      idle(40);

      // Two sections with a gap between them
      ctrl(16, 'h5);
      idle(30);

      // Writes while busy are rejected and flagged
      ctrl(16, 'h2);
      wr(32'(STG_A + 1), rnd512());
      ctrl(8, 'hF);
      idle(15);
      check("busy_reject_error", cfg_error, 1'b1);
      ctrl(2, 'h0);
      idle(20);
      ctrl(16, 'h2);
      idle(20);

      // Randomised traffic
      for (int it = 0; it < 250; it++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 3) wr(32'(STG_A + int'($urandom_range(0, NS + 1))), rnd512());
         else if (op <= 6) ctrl(int'($urandom_range(0, 24)), int'($urandom_range(0, 255)));
         else if (op == 7) wr(others[$urandom_range(0, 4)], rnd512());
         else idle(int'($urandom_range(1, 12)));
      end
      idle(60);
      check("beat_queue_drained", beat_q.size(), 0);
      check("done_queue_drained", done_q.size(), 0);
      check("final_update_count", update_count, 16'(m_count));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
